// File: rtl/gate_tt_checker.sv
// Truth-table checker for a small combinational gate: drives every input vector in order, samples the gate output
// and counts mismatches. Define GATE_CHK_STOP_ON_FAIL_EN to end the sweep at the first mismatching vector.
module gate_tt_checker #(
    parameter int                     N_IN   = 2,
    parameter int                     SETTLE = 2,
    parameter logic [(2**N_IN)-1:0]   TT     = 4'b0001
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] gate_in,
    input  logic            gate_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count
);

    localparam int             CW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int             EW     = N_IN + 1;
    localparam logic [CW-1:0]  RELOAD = CW'(SETTLE - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] settle_cnt;
    logic          sample_now;
    logic          mismatch;
    logic          last_vec;
    logic          stop_now;
    logic [N_IN:0] err_next;

    // The sample is taken on the last cycle of each vector window, when the settle counter has run out
    always_comb begin
        sample_now = (state == S_RUN) && (settle_cnt == '0);
        mismatch   = (gate_out != TT[gate_in]);
        last_vec   = &gate_in;
        err_next   = err_count + EW'(mismatch);
`ifdef GATE_CHK_STOP_ON_FAIL_EN
        stop_now   = sample_now && (mismatch || last_vec);
`else
        stop_now   = sample_now && last_vec;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            settle_cnt <= '0;
            gate_in    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_RUN;
                        settle_cnt <= RELOAD;
                        gate_in    <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_count  <= '0;
                    end
                end
                S_RUN: begin
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - CW'(1);
                    end else begin
                        err_count <= err_next;
                        // On a stop the failing/last vector stays on gate_in for inspection
                        if (stop_now) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_next == '0);
                        end else begin
                            gate_in    <= gate_in + N_IN'(1);
                            settle_cnt <= RELOAD;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_tt_checker.sv
// Bench for gate_tt_checker: two instances (NOR and AND truth tables) drive table-driven gate models; results are
// compared to a reference computed from the vector-by-vector truth-table comparison.
module tb_gate_tt_checker;

    localparam int NV     = 4;
    localparam int SETTLE = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_a = 1'b0, start_b = 1'b0;
    logic [1:0] gate_in_a, gate_in_b;
    logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
    logic [2:0] err_a, err_b;
    logic [3:0] model_a = 4'b0001, model_b = 4'b1000;

    int compared   = 0;
    int mismatched = 0;

    // Gate models are plain lookup tables indexed by the applied vector
    wire gate_out_a = model_a[gate_in_a];
    wire gate_out_b = model_b[gate_in_b];

    always #5 clk = ~clk;

    gate_tt_checker #(.N_IN(2), .SETTLE(SETTLE), .TT(4'b0001)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .gate_in(gate_in_a), .gate_out(gate_out_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a)
    );

    gate_tt_checker #(.N_IN(2), .SETTLE(SETTLE), .TT(4'b1000)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .gate_in(gate_in_b), .gate_out(gate_out_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outcome of one sweep: cycles from the accepting edge to done, error count, vector left on gate_in
    function automatic void refSweep(input logic [3:0] model, input logic [3:0] tt,
                                     output int cycles, output int err, output int last_vec);
        err      = 0;
        cycles   = NV * SETTLE;
        last_vec = NV - 1;
        for (int i = 0; i < NV; i++) begin
            if (model[i] != tt[i]) begin
`ifdef GATE_CHK_STOP_ON_FAIL_EN
                err      = 1;
                cycles   = (i + 1) * SETTLE;
                last_vec = i;
                break;
`else
                err++;
`endif
            end
        end
    endfunction

    // Called at a negedge; the following posedge accepts start
    task automatic applyStimulus(input bit sel);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic runSweep(input bit sel, input logic [3:0] model, input string tag, input int restart_at);
        int cycles, err, last_vec;
        logic [1:0] gi;
        logic       bz, dn, ps;
        logic [2:0] ec;
        refSweep(model, sel ? 4'b1000 : 4'b0001, cycles, err, last_vec);
        if (sel) model_b = model; else model_a = model;
        applyStimulus(sel);
        for (int k = 0; k <= cycles; k++) begin
            if (k > 0) @(negedge clk);
            start_a = 1'b0;
            start_b = 1'b0;
            gi = sel ? gate_in_b : gate_in_a;
            bz = sel ? busy_b : busy_a;
            dn = sel ? done_b : done_a;
            ps = sel ? pass_b : pass_a;
            ec = sel ? err_b : err_a;
            if (k == 0) begin
                checkOutput({tag, "_start_err"}, 32'(ec), 0);
                checkOutput({tag, "_start_pass"}, 32'(ps), 0);
            end
            if (k < cycles) begin
                checkOutput({tag, "_gate_in"}, 32'(gi), k / SETTLE);
                checkOutput({tag, "_busy"}, 32'(bz), 1);
                checkOutput({tag, "_done"}, 32'(dn), 0);
            end else begin
                checkOutput({tag, "_end_gate_in"}, 32'(gi), last_vec);
                checkOutput({tag, "_end_busy"}, 32'(bz), 0);
                checkOutput({tag, "_end_done"}, 32'(dn), 1);
                checkOutput({tag, "_end_err"}, 32'(ec), err);
                checkOutput({tag, "_end_pass"}, 32'(ps), (err == 0) ? 1 : 0);
            end
            if (k == restart_at) begin
                if (sel) start_b = 1'b1; else start_a = 1'b1;
            end
        end
    endtask

    initial begin
        $display("[TB] gate_tt_checker bench starting");
        #1;
        checkOutput("rst_gate_in_a", 32'(gate_in_a), 0);
        checkOutput("rst_busy_a", 32'(busy_a), 0);
        checkOutput("rst_done_a", 32'(done_a), 0);
        checkOutput("rst_pass_a", 32'(pass_a), 0);
        checkOutput("rst_err_a", 32'(err_a), 0);
        checkOutput("rst_done_b", 32'(done_b), 0);
        checkOutput("rst_err_b", 32'(err_b), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        runSweep(1'b0, 4'b0001, "nor_ok", -1);
        runSweep(1'b0, 4'b0000, "stuck0", -1);
        runSweep(1'b0, 4'b1111, "stuck1", -1);
        runSweep(1'b0, 4'b0001, "restart_in_run", 3);
        runSweep(1'b1, 4'b1000, "and_ok", -1);
        runSweep(1'b1, 4'b0001, "and_vs_nor", -1);

        // Abort a failing sweep part-way through with an asynchronous reset
        model_a = 4'b1111;
        applyStimulus(1'b0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_gate_in", 32'(gate_in_a), 0);
        checkOutput("abort_busy", 32'(busy_a), 0);
        checkOutput("abort_done", 32'(done_a), 0);
        checkOutput("abort_err", 32'(err_a), 0);
        checkOutput("abort_pass", 32'(pass_a), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        runSweep(1'b0, 4'b0001, "after_abort", -1);

        for (int r = 0; r < 8; r++) begin
            runSweep(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), "random", -1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
